pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and stall sequencer for the 5-stage pipeline.
//  - Compares D-stage source registers (Tuse) against E/M destination registers (Tnew); holds F/D and bubbles E on RAW hazards.
//  - Tracks the multi-cycle mult/div unit (MDU) with a busy counter; stalls any D-stage MDU instruction while MDU is busy.
//  - Drives write-enables/clears of the F/D/E pipeline registers and the PC; keeps a stall-cycle performance counter.
// PARAMETERS
//  MULT_CYC  5   busy cycles after a mult/multu start
//  DIV_CYC   10  busy cycles after a div/divu start
//  CNT_W     32  width of stall performance counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  d_rs_addr    in   5      D-stage rs index
//  d_rt_addr    in   5      D-stage rt index
//  d_rs_tuse    in   2      cycles until D needs rs; 3 = not used
//  d_rt_tuse    in   2      cycles until D needs rt; 3 = not used
//  d_is_md      in   1      D instr is mult/div/mfhi/mflo/mthi/mtlo
//  e_wa         in   5      E-stage destination reg (0 = none)
//  e_tnew       in   2      cycles until E result is forwardable
//  e_md_start   in   1      E instr is mult/multu/div/divu (start pulse)
//  e_md_is_div  in   1      qualifies e_md_start: 1 = div, 0 = mult
//  m_wa         in   5      M-stage destination reg (0 = none)
//  m_tnew       in   2      cycles until M result is forwardable
//  stall        out  1      hazard present this cycle
//  pc_we        out  1      PC write enable
//  d_we         out  1      F/D register write enable
//  e_clr        out  1      synchronous clear of D/E register (bubble)
//  md_busy      out  1      MDU computing
//  stall_cnt    out  CNT_W  total stalled cycles since reset
// BEHAVIOUR
//  Reset: md_cnt=0, md_busy=0, stall_cnt=0.
//   While reset low: pc_we=0, d_we=0, e_clr=1, stall=0.
//  RAW hazard (combinational):
//   rs_e = (d_rs_addr!=0) & (d_rs_addr==e_wa) & (d_rs_tuse<e_tnew)
//   rs_m = same with m_wa/m_tnew; rt_e, rt_m analogous on rt.
//   tuse=3 never stalls (3 < tnew impossible; tnew<=2).
//  MDU hazard: md_stall = d_is_md & (md_busy | e_md_start).
//  stall = any RAW term | md_stall. Zero-latency combinational outputs from current inputs/state:
//   pc_we=~stall, d_we=~stall, e_clr=stall.
//  MDU counter (md_cnt, width ceil(log2(max(MULT_CYC,DIV_CYC)+1))):
//   e_md_start & md_cnt==0 -> load DIV_CYC if e_md_is_div else MULT_CYC.
//   Otherwise md_cnt!=0 -> decrement. md_busy = (md_cnt!=0), registered state.
//   e_md_start while md_cnt!=0 is ignored (cannot occur legally; must not reload).
//   Load cycle counts as busy from next edge; md_stall covers the start cycle itself via e_md_start.
//  stall_cnt: +1 on each edge where stall=1; saturates at all-ones (no wrap).
//  Reset asserted mid-count: md_cnt and stall_cnt clear immediately (async); no pending stall survives reset.
// TESTING
//  1 Idle, all addr 0, tuse=3 -> stall=0, pc_we=d_we=1, e_clr=0, stall_cnt stays 0.
//  2 D rs=8, tuse=0; E wa=8, tnew=1 -> stall=1, e_clr=1; next cycle E tnew drops (bubble in E), M wa=8, tnew=0 -> stall=0; stall_cnt=1.
//  3 D rt=0 with E wa=0, tnew=2, tuse=0 -> no stall (r0 exempt).
//  4 e_md_start=1, is_div=0; D mfhi on following cycles -> md_busy 1 for exactly 5 cycles; stall held through last busy cycle; releases when md_cnt=0.
//  5 div start -> busy 10 cycles; second e_md_start at cycle 3 -> count not reloaded, busy ends at cycle 10.
//  6 Assert reset at md_cnt=4 with stall=1 -> md_busy=0, stall_cnt=0 asynchronously; pc_we=0 until release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// Detects RAW hazards between the D-stage sources and the E/M destinations.
// Holds D-stage MDU instructions while the multi-cycle mult/div unit is busy.
// Drives the PC and F/D enables and the D/E bubble clear.
// Counts stalled cycles in a saturating performance counter.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,        // active-low, asynchronous
    input  logic [4:0]       d_rs_addr,
    input  logic [4:0]       d_rt_addr,
    input  logic [1:0]       d_rs_tuse,
    input  logic [1:0]       d_rt_tuse,
    input  logic             d_is_md,
    input  logic [4:0]       e_wa,
    input  logic [1:0]       e_tnew,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    input  logic [4:0]       m_wa,
    input  logic [1:0]       m_tnew,
    output logic             stall,
    output logic             pc_we,
    output logic             d_we,
    output logic             e_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    localparam logic [MD_W-1:0] MULT_LD = MD_W'(MULT_CYC);
    localparam logic [MD_W-1:0] DIV_LD  = MD_W'(DIV_CYC);

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_e, rs_m, rt_e, rt_m;
    logic raw_hz, md_stall, hz;

    // RAW terms: a source needed sooner than the producer can forward it.
    // r0 is never a real dependency; tuse=3 cannot be below tnew<=2.
    always_comb begin
        rs_e = (d_rs_addr != 5'd0) && (d_rs_addr == e_wa) && (d_rs_tuse < e_tnew);
        rs_m = (d_rs_addr != 5'd0) && (d_rs_addr == m_wa) && (d_rs_tuse < m_tnew);
        rt_e = (d_rt_addr != 5'd0) && (d_rt_addr == e_wa) && (d_rt_tuse < e_tnew);
        rt_m = (d_rt_addr != 5'd0) && (d_rt_addr == m_wa) && (d_rt_tuse < m_tnew);
        raw_hz = rs_e | rs_m | rt_e | rt_m;
    end

    // MDU hazard covers the start cycle itself through e_md_start, since the
    // counter only reports busy from the following edge.
    always_comb begin
        md_stall = d_is_md & ((md_cnt_q != '0) | e_md_start);
        hz       = raw_hz | md_stall;
    end

    // Pipeline control; reset forces a frozen front end and a bubble in E.
    always_comb begin
        stall   = reset & hz;
        pc_we   = reset & ~hz;
        d_we    = reset & ~hz;
        e_clr   = ~reset | hz;
        md_busy = (md_cnt_q != '0);
        stall_cnt = stall_cnt_q;
    end

    // MDU busy counter: load only from idle so an extra start cannot extend it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start && (md_cnt_q == '0)) begin
            md_cnt_d = e_md_is_div ? DIV_LD : MULT_LD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    // Stall counter advances once per stalled cycle and sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset clears any in-flight MDU count and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
